// File: rtl/serializador_p2s.sv
// serializador_p2s: 8-bit parallel-to-serial converter, one bit per clk.
// Optional trailing parity bit when SERIALIZADOR_PARITY_EN is defined.
// Ports: clk, reset (sync, active-high), enb/data (word strobe + byte),
//        out (registered serial bit), rdy (word can be taken next edge).
// Params: MSB_FIRST (bit order), ODD_PARITY (parity sense, macro only).
module serializador_p2s #(
   parameter int MSB_FIRST  = 1,
   parameter int ODD_PARITY = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic [7:0] data,
   output logic       out,
   output logic       rdy
);

`ifdef SERIALIZADOR_PARITY_EN
   localparam int CW   = 4;
   localparam int LAST = 8;
`else
   localparam int CW   = 3;
   localparam int LAST = 7;
`endif

   // Elaboration guard; also the only use of ODD_PARITY without parity.
   if (MSB_FIRST > 1 || ODD_PARITY > 1) begin : g_param_chk
      $error("serializador_p2s: MSB_FIRST/ODD_PARITY must be 0 or 1");
   end

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        state_q;
   logic [7:0]    word_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          out_q;

   function automatic logic bit_at(input logic [7:0] w,
                                   input logic [2:0] i);
      if (MSB_FIRST != 0) return w[3'd7 - i];
      else                return w[i];
   endfunction

   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   assign rdy = (state_q == IDLE) || (cnt_q == CW'(LAST));
   assign out = out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enb) begin
                  state_q <= SHIFT;
                  word_q  <= data;
                  cnt_q   <= '0;
                  out_q   <= bit_at(data, 3'd0);
               end
            end
            SHIFT: begin
               if (cnt_q == CW'(LAST)) begin
                  // Frame ends: chain the next word with no idle gap.
                  if (enb) begin
                     word_q <= data;
                     cnt_q  <= '0;
                     out_q  <= bit_at(data, 3'd0);
                  end else begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     out_q   <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_d;
`ifdef SERIALIZADOR_PARITY_EN
                  // Parity comes from the captured word, not live data.
                  if (cnt_d == CW'(8))
                     out_q <= (^word_q) ^ ODD_PARITY[0];
                  else
                     out_q <= bit_at(word_q, cnt_d[2:0]);
`else
                  out_q <= bit_at(word_q, cnt_d);
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               out_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serializador_p2s.sv
// tb_serializador_p2s: random + directed bench for serializador_p2s.
// Uses a queue-based frame model; two DUTs cover both parameter sets.
module tb_serializador_p2s;

`ifdef SERIALIZADOR_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   typedef bit bq_t[$];

   logic       clk = 1'b0;
   logic       reset;
   logic       enb;
   logic [7:0] data;
   logic       out0, rdy0;
   logic       out1, rdy1;

   int checks = 0;
   int errors = 0;

   bit  m0_out, m1_out;
   bq_t rem0, rem1;

   always #5 clk = ~clk;

   serializador_p2s #(.MSB_FIRST(1), .ODD_PARITY(0)) dut0 (
      .clk(clk), .reset(reset), .enb(enb), .data(data),
      .out(out0), .rdy(rdy0)
   );

   serializador_p2s #(.MSB_FIRST(0), .ODD_PARITY(1)) dut1 (
      .clk(clk), .reset(reset), .enb(enb), .data(data),
      .out(out1), .rdy(rdy1)
   );

   function automatic bq_t frame(input logic [7:0] w, input bit msb,
                                 input bit odd);
      bq_t q;
      for (int i = 0; i < 8; i++)
         q.push_back(msb ? w[7-i] : w[i]);
`ifdef SERIALIZADOR_PARITY_EN
      q.push_back((^w) ^ odd);
`else
      if (odd) q = q;
`endif
      return q;
   endfunction

   // Drive one cycle at the negedge, advance the model at the posedge.
   task automatic step(input bit r, input bit e, input logic [7:0] d);
      bq_t f;
      reset = r;
      enb   = e;
      data  = d;
      @(posedge clk);
      if (r) begin
         rem0.delete(); rem1.delete();
         m0_out = 0; m1_out = 0;
      end else begin
         if (rem0.size() == 0 && e) begin
            f = frame(d, 1'b1, 1'b0);
            m0_out = f.pop_front(); rem0 = f;
         end else if (rem0.size() != 0) m0_out = rem0.pop_front();
         else m0_out = 0;
         if (rem1.size() == 0 && e) begin
            f = frame(d, 1'b0, 1'b1);
            m1_out = f.pop_front(); rem1 = f;
         end else if (rem1.size() != 0) m1_out = rem1.pop_front();
         else m1_out = 0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1, 1, 8'hFF);
      step(1, 1, 8'h3C);
      checks++;
      if (out0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got %b want 0", out0);
      end
      checks++;
      if (rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdy: got %b want 1", rdy0);
      end
      step(0, 0, 8'h00);
      checks++;
      if (out0 !== 1'b0 || rdy0 !== 1'b1 || out1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: out=%b rdy=%b out1=%b want 0 1 0",
                  out0, rdy0, out1);
      end
   endtask

   task automatic test_single_word();
      bit exp_o[11] = '{1,0,1,0,0,1,0,1,0,0,0};
      step(0, 1, 8'hA5);
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (out0 !== exp_o[i] || out0 !== m0_out) begin
            errors++;
            $display("FAIL single_out[%0d]: got %b want %b", i, out0,
                     exp_o[i]);
         end
         checks++;
         if (rdy0 !== (i >= NB - 1)) begin
            errors++;
            $display("FAIL single_rdy[%0d]: got %b want %b", i, rdy0,
                     (i >= NB - 1));
         end
         step(0, 0, 8'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      bq_t exp_q;
      exp_q = frame(8'h0F, 1'b1, 1'b0);
      exp_q = {exp_q, frame(8'h80, 1'b1, 1'b0)};
      exp_q.push_back(0);
      exp_q.push_back(0);
      step(0, 1, 8'h0F);
      for (int k = 0; k < 2 * NB + 2; k++) begin
         checks++;
         if (out0 !== exp_q[k]) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got %b want %b", k, out0,
                     exp_q[k]);
         end
         step(0, (k < NB), 8'h80);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] w;
      step(0, 1, 8'hFF);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      checks++;
      if (out0 !== 1'b1 || rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit4: out=%b rdy=%b want 1 0", out0, rdy0);
      end
      step(1, 0, 8'h00);
      checks++;
      if (out0 !== 1'b0 || rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: out=%b rdy=%b want 0 1", out0, rdy0);
      end
      step(0, 0, 8'h00);
      checks++;
      if (out0 !== 1'b0 || rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_idle: out=%b rdy=%b want 0 1", out0, rdy0);
      end
      w = 8'($urandom);
      step(0, 1, w);
      for (int i = 0; i < NB + 1; i++) begin
         checks++;
         if (out0 !== m0_out || rdy0 !== (rem0.size() == 0)) begin
            errors++;
            $display("FAIL mid_restart[%0d]: out=%b rdy=%b want %b %b",
                     i, out0, rdy0, m0_out, (rem0.size() == 0));
         end
         step(0, 0, 8'h00);
      end
   endtask

   task automatic test_odd_parity();
      bit eo;
      step(0, 1, 8'h00);
      for (int i = 0; i < NB + 1; i++) begin
`ifdef SERIALIZADOR_PARITY_EN
         eo = (i == 8);
`else
         eo = 0;
`endif
         checks++;
         if (out1 !== eo) begin
            errors++;
            $display("FAIL odd_out[%0d]: got %b want %b", i, out1, eo);
         end
         checks++;
         if (rdy1 !== (i >= NB - 1)) begin
            errors++;
            $display("FAIL odd_rdy[%0d]: got %b want %b", i, rdy1,
                     (i >= NB - 1));
         end
         step(0, 0, 8'h00);
      end
   endtask

   task automatic test_ignore_midframe();
      logic [7:0] w;
      w = 8'($urandom);
      step(0, 1, w);
      for (int i = 0; i < NB + 2; i++) begin
         checks++;
         if (out0 !== m0_out || out1 !== m1_out) begin
            errors++;
            $display("FAIL ignore[%0d]: out0=%b out1=%b want %b %b",
                     i, out0, out1, m0_out, m1_out);
         end
         // Strobe only while busy; the word must be ignored.
         step(0, (rem0.size() != 0), ~w);
      end
   endtask

   task automatic test_random();
      bit r, e;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 1) == 1);
         step(r, e, 8'($urandom));
         checks++;
         if (out0 !== m0_out || rdy0 !== (rem0.size() == 0)) begin
            errors++;
            $display("FAIL rand0[%0d]: out=%b rdy=%b want %b %b",
                     i, out0, rdy0, m0_out, (rem0.size() == 0));
         end
         checks++;
         if (out1 !== m1_out || rdy1 !== (rem1.size() == 0)) begin
            errors++;
            $display("FAIL rand1[%0d]: out=%b rdy=%b want %b %b",
                     i, out1, rdy1, m1_out, (rem1.size() == 0));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      enb   = 1'b0;
      data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_reset_midframe();
      test_odd_parity();
      test_ignore_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule
